// File: rtl/core_pkg.sv
// Shared constants and the fetch-to-decode bundle for the 16-bit Harvard core.
package core_pkg;

    localparam int PC_W    = 6;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0]    RESET_PC    = '0;
    localparam logic [INSTR_W-1:0] HALT_OPCODE = 32'hFFFF_FFFF;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_bundle_t;

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready holding register for a pipeline boundary.
// flush beats load, load beats a plain handshake drain.
module fetch_out_reg
    import core_pkg::*;
#(
    parameter int WIDTH = $bits(fetch_bundle_t)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             flush,
    input  logic             ready,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    // Slot register: capture on load, empty on flush or when drained.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational instruction memory and
// hands {instr, pc} to decode through a valid/ready slot. Supports stall,
// branch redirect with flush, and halting on the HALT opcode.
module instr_fetch_unit
#(
    parameter int                 PC_W        = core_pkg::PC_W,
    parameter int                 INSTR_W     = core_pkg::INSTR_W,
    parameter logic [PC_W-1:0]    RESET_PC    = core_pkg::RESET_PC,
    parameter logic [INSTR_W-1:0] HALT_OPCODE = core_pkg::HALT_OPCODE
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               branch_valid,
    input  logic [PC_W-1:0]    branch_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic               halted
);

    localparam int SLOT_W = INSTR_W + PC_W;

    logic [PC_W-1:0]   pc_p0;
    logic [PC_W-1:0]   pc_next;
    logic              halted_p0;
    logic              halt_set;
    logic              load;
    logic              slot_free;
    logic              word_is_halt;
    logic [SLOT_W-1:0] slot_q;

    assign imem_addr    = pc_p0;
    assign halted       = halted_p0;
    assign slot_free    = !out_valid || out_ready;
    assign word_is_halt = (imem_data == HALT_OPCODE);

    // Next PC and capture decision: branch, then halted, then advance, else stall.
    always_comb begin
        pc_next  = pc_p0;
        load     = 1'b0;
        halt_set = 1'b0;
        if (branch_valid) begin
            pc_next = branch_target;
        end else if (!halted_p0 && slot_free) begin
            load = 1'b1;
            if (word_is_halt) begin
                // PC parks on the HALT word; only a branch moves it again.
                halt_set = 1'b1;
            end else begin
                pc_next = pc_p0 + PC_W'(1);
            end
        end
    end

    // ---- stage p0: program counter and halt flag ----
    // PC and halt flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_p0     <= RESET_PC;
            halted_p0 <= 1'b0;
        end else begin
            pc_p0 <= pc_next;
            if (branch_valid) begin
                halted_p0 <= 1'b0;
            end else if (halt_set) begin
                halted_p0 <= 1'b1;
            end
        end
    end

    // ---- stage p1: output slot to decode ----
    fetch_out_reg #(
        .WIDTH (SLOT_W)
    ) u_out_reg (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .flush (branch_valid),
        .ready (out_ready),
        .d     ({imem_data, pc_p0}),
        .valid (out_valid),
        .q     (slot_q)
    );

    assign out_instr = slot_q[PC_W +: INSTR_W];
    assign out_pc    = slot_q[PC_W-1:0];

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end fetch stage of the 16-bit Harvard core. Owns the program counter and drives the address of the combinational instruction memory.
- Registers each returned 32-bit instruction, with its PC, into a valid/ready output slot consumed by the decode/ALU stage.
- Adds three things a free-running counter lacks: back-pressure stall, branch redirect with flush, and halt on a HALT opcode.

Parameters:
- PC_W, 6, program counter and instruction-memory address width (64 words)
- INSTR_W, 32, instruction word width
- RESET_PC, 0, PC value loaded on reset
- HALT_OPCODE, 32'hFFFF_FFFF, instruction word that stops fetching

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- imem_addr  output  PC_W  address to instruction memory; always equals the current PC register
- imem_data  input  INSTR_W  instruction memory read data; combinational from imem_addr, same cycle
- branch_valid  input  1  redirect request from a downstream stage, single-cycle pulse
- branch_target  input  PC_W  new PC, sampled when branch_valid=1
- out_valid  output  1  out_instr/out_pc hold a valid instruction
- out_ready  input  1  consumer accepts the slot this cycle
- out_instr  output  INSTR_W  fetched instruction
- out_pc  output  PC_W  address the instruction was fetched from
- halted  output  1  fetch stopped by HALT_OPCODE

Behaviour:
- Reset (async, active-high), while asserted:
  - pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0.
  - imem_addr=RESET_PC.
- Slot is "free" when out_valid=0 OR (out_valid=1 AND out_ready=1).
- Per rising edge, in priority order:
  1. Branch (branch_valid=1):
     - pc<=branch_target; out_valid<=0 (in-flight slot flushed, even if out_ready=1 that cycle); halted<=0.
     - No capture this cycle.
  2. Halted (halted=1):
     - pc holds; no capture.
     - out_valid clears when out_ready=1, otherwise holds.
  3. Advance (slot free):
     - out_instr<=imem_data; out_pc<=pc; out_valid<=1; pc<=pc+1, modulo 2^PC_W, so 63 wraps to 0.
     - If imem_data==HALT_OPCODE: halted<=1 and pc holds. The HALT word is still delivered on out_instr.
  4. Stall (out_valid=1 AND out_ready=0):
     - pc, out_instr, out_pc, out_valid all hold.
- Timing:
  - Latency is 1 cycle from address to output. The first edge with reset low presents mem[RESET_PC] with out_pc=RESET_PC.
  - Throughput is 1 instruction per cycle when out_ready is held high.
- Branch to the current PC is legal and refetches that word.
- branch_valid during reset is ignored.
- Reset mid-stall or mid-halt returns every output to its reset values immediately (async).
- out_instr/out_pc are don't-care when out_valid=0; the bench checks them only when valid.
- No combinational path from out_ready or branch_valid to any output.

Decomposition:
- Shared package (core_pkg) holds PC_W, INSTR_W, RESET_PC and HALT_OPCODE as constants, plus a fetch_bundle typedef {instr, pc}. The decode/ALU stage reuses the typedef.
- One sub-module is natural: fetch_out_reg, the valid/ready holding register. It takes load, flush and ready inputs and is reusable for later pipeline boundaries.
- PC next-state logic stays in the top module.

Test Plan:
- Straight-line run: reset for 2 cycles, out_ready=1, mem[i]=i+100 → out_pc=0,1,2,… with out_instr=100,101,102,… on consecutive cycles; first out_valid on the first edge after reset falls.
- Stall: assert out_ready=0 for 3 cycles while out_pc=4 → out_pc=4 and out_instr=104 are held, and imem_addr stays 5. After release, out_pc=5 appears the next cycle with no word lost or duplicated.
- Branch flush: pulse branch_valid with target=20 while out_pc=7 is valid → out_valid=0 next cycle, then out_pc=20 / out_instr=120. Repeat the pulse during a stall → same result, and the stalled word is dropped.
- Wrap-around: branch to 62 → out_pc sequence is 62, 63, 0, 1.
- Halt: mem[10]=HALT_OPCODE → out_instr=FFFFFFFF with out_pc=10, halted=1, and no further fetches (imem_addr=10). A later branch to 0 clears halted and resumes at out_pc=0.
- Async reset mid-stall: raise reset between clock edges while out_valid=1 → out_valid=0, halted=0 and imem_addr=0 immediately, with no clock edge required.
